// File: rtl/motion_pkg.sv
// Shared types and defaults for the motion-mask pixel comparator.
package motion_pkg;

  // Grayscale sample width.
  localparam int unsigned GRAY_W = 8;

  // Default strict greater-than limit on the per-pixel absolute difference.
  localparam logic [GRAY_W-1:0] DEF_THRESHOLD = 8'd50;

  // Default frame size: 720 x 540 pixels.
  localparam int unsigned DEF_PIXELS = 388800;

  // One-hot encoding leaves 2'b00 and 2'b11 as illegal codes that must be recovered from.
  typedef enum logic [1:0] {
    S_READ  = 2'b01,
    S_WRITE = 2'b10
  } state_t;

endpackage

// File: rtl/motion_mask.sv
// Motion mask: pops one background and one frame pixel together, flags motion when the
// absolute grayscale difference exceeds THRESHOLD, and pushes the flag one cycle later.
module motion_mask
  import motion_pkg::*;
#(
  parameter logic [GRAY_W-1:0] THRESHOLD = DEF_THRESHOLD,
  parameter int unsigned       PIXELS    = DEF_PIXELS
) (
  input  logic              clock,
  input  logic              reset,
  output logic              bg_rd_en,
  input  logic              bg_empty,
  input  logic [GRAY_W-1:0] bg_dout,
  output logic              fr_rd_en,
  input  logic              fr_empty,
  input  logic [GRAY_W-1:0] fr_dout,
  output logic              out_wr_en,
  input  logic              out_full,
  output logic              out_din,
  output logic              frame_done
);

  localparam int unsigned     CNT_W    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIXELS - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_flag;
  logic              w_flag_next;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic [CNT_W-1:0]  w_pix_cnt_next;

  logic [GRAY_W:0]   w_fr_ext;
  logic [GRAY_W:0]   w_bg_ext;
  logic [GRAY_W:0]   w_mag;
  logic              w_motion;

  // Magnitude is formed in 9 bits by subtracting the smaller operand, so it never wraps.
  assign w_fr_ext = {1'b0, fr_dout};
  assign w_bg_ext = {1'b0, bg_dout};
  assign w_mag    = (w_fr_ext >= w_bg_ext) ? (w_fr_ext - w_bg_ext) : (w_bg_ext - w_fr_ext);
  assign w_motion = (w_mag > {1'b0, THRESHOLD});

  // Next-state, flag capture, pixel counting and FIFO strobes.
  always_comb begin
    w_state_next   = r_state;
    w_flag_next    = r_flag;
    w_pix_cnt_next = r_pix_cnt;
    bg_rd_en       = 1'b0;
    fr_rd_en       = 1'b0;
    out_wr_en      = 1'b0;
    out_din        = 1'b0;
    frame_done     = 1'b0;

    unique case (r_state)
      S_READ: begin
        if (!bg_empty && !fr_empty) begin
          bg_rd_en     = 1'b1;
          fr_rd_en     = 1'b1;
          w_flag_next  = w_motion;
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!out_full) begin
          out_wr_en    = 1'b1;
          out_din      = r_flag;
          w_state_next = S_READ;
          if (r_pix_cnt == LAST_PIX) begin
            w_pix_cnt_next = '0;
            frame_done     = 1'b1;
          end else begin
            w_pix_cnt_next = r_pix_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_READ;
      end
    endcase

    // Strobes stay quiet for the whole reset cycle, whatever state is currently held.
    if (reset) begin
      bg_rd_en   = 1'b0;
      fr_rd_en   = 1'b0;
      out_wr_en  = 1'b0;
      out_din    = 1'b0;
      frame_done = 1'b0;
    end
  end

  // State, held flag and pixel counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_READ;
      r_flag    <= 1'b0;
      r_pix_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_flag    <= w_flag_next;
      r_pix_cnt <= w_pix_cnt_next;
    end
  end

endmodule

// File: tb/tb_motion_mask.sv
// Self-checking bench for motion_mask: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_motion_mask;

  localparam int unsigned P   = 4;
  localparam int unsigned THR = 50;

  logic       clock;
  logic       reset;
  logic       bg_rd_en;
  logic       bg_empty;
  logic [7:0] bg_dout;
  logic       fr_rd_en;
  logic       fr_empty;
  logic [7:0] fr_dout;
  logic       out_wr_en;
  logic       out_full;
  logic       out_din;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  // Reference model: at most one popped-but-unwritten flag, plus writes seen in this frame.
  bit model_q[$];
  int model_cnt = 0;

  logic last_wr;
  logic last_din;
  logic last_fd;

  typedef struct {
    logic [7:0] fr;
    logic [7:0] bg;
    logic       flag;
  } vec_t;

  vec_t vecs[10];

  motion_mask #(
    .THRESHOLD(8'd50),
    .PIXELS   (P)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bg_rd_en  (bg_rd_en),
    .bg_empty  (bg_empty),
    .bg_dout   (bg_dout),
    .fr_rd_en  (fr_rd_en),
    .fr_empty  (fr_empty),
    .fr_dout   (fr_dout),
    .out_wr_en (out_wr_en),
    .out_full  (out_full),
    .out_din   (out_din),
    .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit motion(input int fr, input int bg);
    int d;
    d = fr - bg;
    if (d < 0) d = -d;
    return d > THR;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle against the model, then advance.
  task automatic do_cycle(input logic rst, input logic bge, input logic fre,
                          input logic full, input logic [7:0] fr, input logic [7:0] bg);
    logic e_rd, e_wr, e_din, e_fd;
    reset    = rst;
    bg_empty = bge;
    fr_empty = fre;
    out_full = full;
    fr_dout  = fr;
    bg_dout  = bg;
    @(negedge clock);
    e_rd = 1'b0; e_wr = 1'b0; e_din = 1'b0; e_fd = 1'b0;
    if (!rst) begin
      if (model_q.size() > 0) begin
        e_wr  = !full;
        e_din = e_wr ? model_q[0] : 1'b0;
        e_fd  = e_wr && (model_cnt == P - 1);
      end else begin
        e_rd = !bge && !fre;
      end
    end
    chk("bg_rd_en", bg_rd_en, e_rd);
    chk("fr_rd_en", fr_rd_en, e_rd);
    chk("out_wr_en", out_wr_en, e_wr);
    chk("out_din", out_din, e_din);
    chk("frame_done", frame_done, e_fd);
    last_wr  = out_wr_en;
    last_din = out_din;
    last_fd  = frame_done;
    if (rst) begin
      model_q.delete();
      model_cnt = 0;
    end else if (e_wr) begin
      void'(model_q.pop_front());
      model_cnt = (model_cnt + 1) % P;
    end else if (e_rd) begin
      model_q.push_back(motion(fr, bg));
    end
    @(posedge clock);
    #1;
  endtask

  // Pop then push one pixel with all FIFOs ready.
  task automatic pixel(input logic [7:0] fr, input logic [7:0] bg);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, fr, bg);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, fr, bg);
  endtask

  initial begin
    vecs[0] = '{fr: 8'd200, bg: 8'd100, flag: 1'b1};
    vecs[1] = '{fr: 8'd100, bg: 8'd150, flag: 1'b0};
    vecs[2] = '{fr: 8'd100, bg: 8'd151, flag: 1'b1};
    vecs[3] = '{fr: 8'd0,   bg: 8'd255, flag: 1'b1};
    vecs[4] = '{fr: 8'd255, bg: 8'd0,   flag: 1'b1};
    vecs[5] = '{fr: 8'd50,  bg: 8'd0,   flag: 1'b0};
    vecs[6] = '{fr: 8'd0,   bg: 8'd51,  flag: 1'b1};
    vecs[7] = '{fr: 8'd7,   bg: 8'd7,   flag: 1'b0};
    vecs[8] = '{fr: 8'd100, bg: 8'd49,  flag: 1'b1};
    vecs[9] = '{fr: 8'd100, bg: 8'd50,  flag: 1'b0};

    // Reset with both input FIFOs non-empty: nothing may be popped.
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd200, 8'd100);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd200, 8'd100);

    // Vector table; writes 4 and 8 close a 4-pixel frame.
    for (int i = 0; i < 10; i++) begin
      pixel(vecs[i].fr, vecs[i].bg);
      chk("vec_write", last_wr, 1'b1);
      chk("vec_flag", last_din, vecs[i].flag);
      chk("vec_frame_done", last_fd, (i == 3) || (i == 7));
    end

    // Frame FIFO empty for 10 cycles, then released.
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'd200, 8'd100);
    pixel(8'd200, 8'd100);
    chk("after_starve_flag", last_din, 1'b1);

    // Output FIFO full for 5 cycles with a held motion flag; inputs change meanwhile.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd200, 8'd100);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd100, 8'd100);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd100, 8'd100);
    chk("stall_write", last_wr, 1'b1);
    chk("stall_retained_flag", last_din, 1'b1);

    // Reset while holding a motion flag: it is dropped and the frame count restarts.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 8'd0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd255, 8'd0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'd255, 8'd0);
    chk("no_write_after_reset", last_wr, 1'b0);

    // Nine pixels from a fresh count: frame_done on writes 4 and 8 only.
    for (int k = 1; k <= 9; k++) begin
      pixel(8'(k * 20), 8'd90);
      chk("stream_frame_done", last_fd, (k == 4) || (k == 8));
    end

    // Randomized traffic, occasional resets.
    for (int i = 0; i < 600; i++) begin
      do_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
